// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the pipeline and the multiply/divide engine.
// master = pipeline side (issues operations), slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide engine for MIPS mult/multu/div/divu.
// Define MULDIV_FAST_MULT_EN to form mult/multu products with a single-cycle multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     res_lo_q, res_lo_d;
  logic [WIDTH-1:0]     res_hi_q, res_hi_d;
  logic                 dbz_q, dbz_d;
  logic                 done_q, done_d;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Multiply step: conditionally add multiplicand into the upper half, then shift the
  // whole {carry, hi, lo} right; the multiplier bits are consumed from acc_q[0].
  logic [WIDTH:0]   mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);

  // Restoring divide step: hi holds the partial remainder, lo shifts the dividend out
  // MSB first and the quotient bits in LSB first.
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  assign div_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge  = (div_sh >= {1'b0, mag_b_q});
  assign div_rem = div_ge ? (div_sh[WIDTH-1:0] - mag_b_q) : div_sh[WIDTH-1:0];

  logic [WIDTH-1:0] raw_a;
  assign raw_a = neg_if(mag_a_q, sign_a_q);

`ifdef MULDIV_FAST_MULT_EN
  logic [WIDTH-1:0]          raw_b;
  logic signed [2*WIDTH-1:0] fm_a, fm_b, fm_prod;
  assign raw_b   = neg_if(mag_b_q, sign_b_q);
  assign fm_a    = {{WIDTH{sign_a_q}}, raw_a};
  assign fm_b    = {{WIDTH{sign_b_q}}, raw_b};
  assign fm_prod = fm_a * fm_b;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          sign_a_d = ~bus.op[0] & bus.src_a[WIDTH-1];
          sign_b_d = ~bus.op[0] & bus.src_b[WIDTH-1];
          mag_a_d  = neg_if(bus.src_a, sign_a_d);
          mag_b_d  = neg_if(bus.src_b, sign_b_d);
          acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a_d : mag_b_d)};
          cnt_d    = '0;
          dbz_d    = 1'b0;
          state_d  = S_RUN;
`ifdef MULDIV_FAST_MULT_EN
          if (!bus.op[1]) state_d = S_FIX;
`endif
        end
      end

      S_RUN: begin
        if (is_div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        else          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          if (mag_b_q == '0) begin
            res_lo_d = '1;
            res_hi_d = raw_a;
            dbz_d    = 1'b1;
          end else begin
            res_lo_d = neg_if(acc_q[WIDTH-1:0], sign_a_q ^ sign_b_q);
            res_hi_d = neg_if(acc_q[2*WIDTH-1:WIDTH], sign_a_q);
          end
        end else begin
`ifdef MULDIV_FAST_MULT_EN
          {res_hi_d, res_lo_d} = fm_prod;
`else
          {res_hi_d, res_lo_d} = neg_if_wide(acc_q, sign_a_q ^ sign_b_q);
`endif
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.result_lo   = res_lo_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of hand-computed results plus
// sequences for ignored start, mid-operation reset and back-to-back issue.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_latency(input logic [1:0] op);
`ifdef MULDIV_FAST_MULT_EN
    return op[1] ? 34 : 2;
`else
    return 34;
`endif
  endfunction

  // Drives start in cycle 0 and returns positioned in cycle 1 with start released.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Advances from cycle 1 until done; returns the done cycle, or -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    if (bus.done !== 1'b1) cyc = -1;
  endtask

  task automatic run_vec(input int i);
    int cyc;
    string tag;
    tag = $sformatf("vec%0d", i);
    launch(vecs[i].op, vecs[i].a, vecs[i].b);
    check({tag, " busy@1"}, 64'(bus.busy), 64'd1);
    check({tag, " dbz_clear@1"}, 64'(bus.div_by_zero), 64'd0);
    wait_done(cyc);
    check({tag, " latency"}, 64'(cyc), 64'(exp_latency(vecs[i].op)));
    check({tag, " busy@done"}, 64'(bus.busy), 64'd0);
    check({tag, " lo"}, 64'(bus.result_lo), 64'(vecs[i].lo));
    check({tag, " hi"}, 64'(bus.result_hi), 64'(vecs[i].hi));
    check({tag, " dbz"}, 64'(bus.div_by_zero), 64'(vecs[i].dbz));
    tick();
    check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, " lo_held"}, 64'(bus.result_lo), 64'(vecs[i].lo));
  endtask

  initial begin
    int cyc, ndone, first_done;
    n_tests = 0;
    n_fail  = 0;

    //           op     a             b             lo            hi            dbz
    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000003, 32'h00000001, 1'b0};
    vecs[4]  = '{2'b11, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 1'b1};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0};
    vecs[7]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0};
    vecs[8]  = '{2'b10, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0};
    vecs[9]  = '{2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 1'b0};
    vecs[10] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};
    vecs[11] = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
    vecs[12] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[13] = '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0};

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    reset     = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset lo",   64'(bus.result_lo), 64'd0);
    check("reset hi",   64'(bus.result_hi), 64'd0);
    check("reset dbz",  64'(bus.div_by_zero), 64'd0);

    for (int i = 0; i < 14; i++) run_vec(i);

    // A start pulse while busy must be ignored and produce no extra done.
    launch(2'b11, 32'd7, 32'd2);
    ndone = 0;
    first_done = -1;
    for (int c = 1; c <= 80; c++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      if (c == 10) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = 32'd3;
        bus.src_b = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (c < 80) tick();
    end
    check("ignored start ndone", 64'(ndone), 64'd1);
    check("ignored start cycle", 64'(first_done), 64'd34);
    check("ignored start lo", 64'(bus.result_lo), 64'd3);
    check("ignored start hi", 64'(bus.result_hi), 64'd1);

    // Reset in cycle 10 aborts the operation and clears results.
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort lo",   64'(bus.result_lo), 64'd0);
    check("abort hi",   64'(bus.result_hi), 64'd0);
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.done === 1'b1) ndone++;
      tick();
    end
    check("abort no done", 64'(ndone), 64'd0);

    // Start in the done cycle is accepted; second done 34 cycles later.
    launch(2'b11, 32'd7, 32'd2);
    wait_done(cyc);
    check("b2b first latency", 64'(cyc), 64'd34);
    check("b2b first lo", 64'(bus.result_lo), 64'd3);
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    check("b2b accepted busy", 64'(bus.busy), 64'd1);
    wait_done(cyc);
    check("b2b second latency", 64'(cyc), 64'd34);
    check("b2b second lo", 64'(bus.result_lo), 64'hFFFFFFFD);
    check("b2b second hi", 64'(bus.result_hi), 64'hFFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
